cnu_serial: RTL and testbench
=============================

Name: cnu_serial

Overview:
Serial min-sum check node unit (CNU), the counterpart of the variable node unit in the LDPC decoder datapath. It consumes the DC variable-to-check messages (q) of one check node, one per cycle, over a valid/ready stream. It then emits the DC check-to-variable messages (r) in the same edge order, plus a parity-check flag. It also computes one syndrome bit per check for early-termination logic.

Parameters:
data_w, 8, message width; two's complement, same format as VNU q/r.
DC, 6, check node degree (edges per check), >= 2.
OFFSET, 1, offset subtracted from output magnitude; used only when CNU_OFFSET_EN is defined.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  q_in valid
in_ready  output  1  CNU accepts q_in this cycle
q_in  input  data_w  variable-to-check message, edge order 0..DC-1
out_valid  output  1  r_out valid
out_ready  input  1  downstream accepts r_out
r_out  output  data_w  check-to-variable message, edge order 0..DC-1
out_last  output  1  high with edge DC-1 output
parity_ok  output  1  sign parity of the collected q set is even; valid while out_valid

Behaviour:
- Reset (async assert, sync release): state=COLLECT, edge counter=0, min1=min2=2^(data_w-1)-1, idx=0, sign_acc=0, sign register=0. Outputs: in_ready=1, out_valid=0, out_last=0, r_out=0, parity_ok=0.
- Two states, COLLECT and EMIT. The edge counter is shared by both states and runs 0..DC-1, width log2(DC).
- COLLECT:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: compute mag=|q_in|; -2^(data_w-1) saturates to 2^(data_w-1)-1.
  - sign=q_in[data_w-1]; zero counts as positive.
  - Store sign[cnt]; sign_acc ^= sign.
  - If mag < min1 (strict): min2<=min1, min1<=mag, idx<=cnt. Else if mag < min2: min2<=mag. Ties keep the earlier index.
  - When cnt==DC-1 is accepted: cnt<=0, go to EMIT.
  - in_valid low: no state change.
- EMIT:
  - in_ready=0, out_valid=1. Output is registered, so the first r_out is valid the cycle after the last q is accepted.
  - For edge cnt: m = (cnt==idx) ? min2 : min1; s = sign_acc ^ sign[cnt]; r_out = s ? -m : m. Zero magnitude gives 0 regardless of s.
  - out_last=(cnt==DC-1). parity_ok=~sign_acc, held constant through EMIT.
  - On out_valid&&out_ready: cnt++. On the last edge: go to COLLECT, reinit min1/min2/idx/sign_acc.
  - out_ready low: r_out, out_last and parity_ok hold stable (AXI-style; no change while valid && !ready).
- No in/out overlap. Throughput: 2*DC cycles per check with no stalls.
- Width rules:
  - Magnitudes are data_w-1 bits, unsigned.
  - Negation of any m <= 2^(data_w-1)-1 cannot overflow.
  - Output range is symmetric: -(2^(data_w-1)-1)..2^(data_w-1)-1.
- rst_n asserted mid-COLLECT or mid-EMIT: partial data is discarded immediately; outputs return to reset values asynchronously.

Optional Feature:
- Macro: CNU_OFFSET_EN.
- Defined: offset min-sum. m' = (m > OFFSET) ? m-OFFSET : 0, applied to both min1 and min2 selections before the sign is applied.
- Undefined: plain min-sum; OFFSET is ignored. Latency is identical in both builds.

Test Plan:
- Basic min-sum (DC=6, data_w=8, no stalls): q = 5,-3,7,2,-9,4.
  - Required: r = 2,-2,2,3,-2,2; parity_ok=1; out_last only with the 6th output.
  - First out_valid occurs 1 cycle after the 6th accept.
- Saturation: q = -128 x6.
  - Required: r = -127 x6; parity_ok=1.
- Odd parity and ties: q = 4,-4,10,10,10,10.
  - min1=4 at idx 0, min2=4, sign_acc=1.
  - Required: r = -4,4,-4,-4,-4,-4; parity_ok=0.
- Backpressure and input gaps:
  - Insert in_valid gaps while feeding the basic vector; hold out_ready=0 for 3 cycles on edge 2.
  - Required: r_out=2 held stable throughout the stall; sequence unchanged; in_ready=0 during all of EMIT.
- Offset build (CNU_OFFSET_EN, OFFSET=1), basic vector.
  - Required: r = 1,-1,1,2,-1,1.
  - Also q = 1,1,5,5,5,5 -> r = 0 x6.
- Reset mid-operation:
  - Assert rst_n=0 after 3 accepts, then feed the basic vector.
  - Required: outputs at reset values during reset; next output set = 2,-2,2,3,-2,2 with no residue from the aborted check.

Source files
------------

// File: rtl/cnu_serial.sv
// Serial min-sum check node unit: collects DC q messages, then emits DC r messages plus parity.
// Optional offset min-sum when CNU_OFFSET_EN is defined (OFFSET subtracted from output magnitude).
module cnu_serial #(
  parameter int data_w = 8,
  parameter int DC     = 6,
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] q_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w-1:0] r_out,
  output logic              out_last,
  output logic              parity_ok
);

  localparam int MW = data_w - 1;
  localparam int CW = (DC > 1) ? $clog2(DC) : 1;
  localparam logic [MW-1:0]     MAG_MAX = {MW{1'b1}};
  localparam logic [CW-1:0]     LAST    = CW'(DC - 1);
  localparam logic [data_w-1:0] MOST_NEG = {1'b1, {MW{1'b0}}};

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     min1_q, min1_d;
  logic [MW-1:0]     min2_q, min2_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic              sign_acc_q, sign_acc_d;
  logic [DC-1:0]     sign_q, sign_d;
  logic [data_w-1:0] r_out_q, r_out_d;
  logic              out_last_q, out_last_d;
  logic              parity_ok_q, parity_ok_d;

  logic [MW-1:0]     mag;
  logic              sgn;
  logic [CW-1:0]     cnt_inc;

  // Most-negative input saturates so every magnitude fits in data_w-1 bits.
  function automatic logic [MW-1:0] mag_of(input logic [data_w-1:0] q);
    logic [data_w-1:0] neg;
    logic [MW-1:0]     res;
    neg = -q;
    if (!q[data_w-1])
      res = q[MW-1:0];
    else if (q == MOST_NEG)
      res = MAG_MAX;
    else
      res = neg[MW-1:0];
    return res;
  endfunction

`ifdef CNU_OFFSET_EN
  localparam logic [MW-1:0] OFFSET_M = MW'(OFFSET);
  function automatic logic [MW-1:0] shape(input logic [MW-1:0] m);
    return (m > OFFSET_M) ? (m - OFFSET_M) : '0;
  endfunction
`else
  function automatic logic [MW-1:0] shape(input logic [MW-1:0] m);
    return m;
  endfunction
`endif

  function automatic logic [data_w-1:0] r_of(
    input logic [CW-1:0] e,
    input logic [MW-1:0] m1,
    input logic [MW-1:0] m2,
    input logic [CW-1:0] ix,
    input logic          sacc,
    input logic [DC-1:0] sg
  );
    logic [MW-1:0]     m;
    logic [data_w-1:0] mx;
    m  = shape((e == ix) ? m2 : m1);
    mx = {1'b0, m};
    return (sacc ^ sg[e]) ? -mx : mx;
  endfunction

  assign mag     = mag_of(q_in);
  assign sgn     = q_in[data_w-1];
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    min1_d      = min1_q;
    min2_d      = min2_q;
    idx_d       = idx_q;
    sign_acc_d  = sign_acc_q;
    sign_d      = sign_q;
    r_out_d     = r_out_q;
    out_last_d  = out_last_q;
    parity_ok_d = parity_ok_q;

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          sign_d[cnt_q] = sgn;
          sign_acc_d    = sign_acc_q ^ sgn;
          // Strict compares: on a tie the earlier edge keeps min1.
          if (mag < min1_q) begin
            min2_d = min1_q;
            min1_d = mag;
            idx_d  = cnt_q;
          end else if (mag < min2_q) begin
            min2_d = mag;
          end
          if (cnt_q == LAST) begin
            cnt_d       = '0;
            state_d     = EMIT;
            r_out_d     = r_of('0, min1_d, min2_d, idx_d, sign_acc_d, sign_d);
            out_last_d  = (LAST == '0);
            parity_ok_d = ~sign_acc_d;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d     = COLLECT;
            cnt_d       = '0;
            min1_d      = MAG_MAX;
            min2_d      = MAG_MAX;
            idx_d       = '0;
            sign_acc_d  = 1'b0;
            r_out_d     = '0;
            out_last_d  = 1'b0;
            parity_ok_d = 1'b0;
          end else begin
            cnt_d      = cnt_inc;
            r_out_d    = r_of(cnt_inc, min1_q, min2_q, idx_q, sign_acc_q, sign_q);
            out_last_d = (cnt_inc == LAST);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      min1_q      <= MAG_MAX;
      min2_q      <= MAG_MAX;
      idx_q       <= '0;
      sign_acc_q  <= 1'b0;
      sign_q      <= '0;
      r_out_q     <= '0;
      out_last_q  <= 1'b0;
      parity_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      min1_q      <= min1_d;
      min2_q      <= min2_d;
      idx_q       <= idx_d;
      sign_acc_q  <= sign_acc_d;
      sign_q      <= sign_d;
      r_out_q     <= r_out_d;
      out_last_q  <= out_last_d;
      parity_ok_q <= parity_ok_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == EMIT);
  assign r_out     = r_out_q;
  assign out_last  = out_last_q;
  assign parity_ok = parity_ok_q;

endmodule

// File: tb/tb_cnu_serial.sv
// Bench for cnu_serial (DC=6, data_w=8): directed vector table, hand-written corner sequences,
// and randomized checks against an exclude-self min/sign reference model.
module tb_cnu_serial;

  localparam int DW  = 8;
  localparam int NDC = 6;
  localparam int OFF = 1;

  typedef logic [NDC-1:0][DW-1:0] vec6_t;
  typedef struct packed {
    vec6_t q;
    vec6_t r;
    logic  par;
  } tvec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] q_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] r_out;
  logic          out_last;
  logic          parity_ok;

  int n_cmp = 0;
  int n_bad = 0;

  cnu_serial #(.data_w(DW), .DC(NDC), .OFFSET(OFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .q_in(q_in),
    .out_valid(out_valid), .out_ready(out_ready), .r_out(r_out),
    .out_last(out_last), .parity_ok(parity_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec6_t pk(input int a0, input int a1, input int a2,
                               input int a3, input int a4, input int a5);
    vec6_t v;
    v[0] = 8'(a0); v[1] = 8'(a1); v[2] = 8'(a2);
    v[3] = 8'(a3); v[4] = 8'(a4); v[5] = 8'(a5);
    return v;
  endfunction

  // Reference: r[e] is the min |q| and sign product over all other edges.
  function automatic vec6_t model_r(input vec6_t q);
    vec6_t r;
    for (int e = 0; e < NDC; e++) begin
      int m = 127;
      int s = 0;
      for (int j = 0; j < NDC; j++) begin
        if (j != e) begin
          int v = $signed(q[j]);
          int a = (v < 0) ? -v : v;
          if (a > 127) a = 127;
          if (a < m) m = a;
          if (v < 0) s = s ^ 1;
        end
      end
`ifdef CNU_OFFSET_EN
      m = (m > OFF) ? m - OFF : 0;
`endif
      r[e] = 8'(s ? -m : m);
    end
    return r;
  endfunction

  function automatic logic model_par(input vec6_t q);
    int neg = 0;
    for (int j = 0; j < NDC; j++) if (q[j][DW-1]) neg++;
    return (neg % 2) == 0;
  endfunction

  // gap_mode: 0 none, 1 two idle cycles before each odd edge, 2 random 0..2 idle cycles.
  task automatic feed(input vec6_t q, input int gap_mode);
    for (int e = 0; e < NDC; e++) begin
      int g;
      g = (gap_mode == 1) ? ((e % 2) ? 2 : 0) : (gap_mode == 2) ? $urandom_range(2, 0) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_no_out_valid", out_valid, 0);
      end
      in_valid = 1'b1;
      q_in = q[e];
      #1;
      chk("in_ready_collect", in_ready, 1);
      chk("out_valid_collect", out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("first_out_valid_latency", out_valid, 1);
  endtask

  task automatic drain(input vec6_t r, input logic par, input int stall_edge,
                       input int stall_len, input bit rnd);
    for (int e = 0; e < NDC; e++) begin
      int st;
      st = rnd ? $urandom_range(2, 0) : ((e == stall_edge) ? stall_len : 0);
      chk("out_valid_emit", out_valid, 1);
      chk("r_out", $signed(r_out), $signed(r[e]));
      chk("out_last", out_last, (e == NDC - 1) ? 1 : 0);
      chk("parity_ok", parity_ok, par);
      chk("in_ready_emit", in_ready, 0);
      out_ready = 1'b0;
      repeat (st) begin
        @(posedge clk); #1;
        chk("stall_r_out_hold", $signed(r_out), $signed(r[e]));
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_last_hold", out_last, (e == NDC - 1) ? 1 : 0);
        chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("out_valid_after_emit", out_valid, 0);
    chk("in_ready_after_emit", in_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_r_out"}, r_out, 0);
    chk({tag, "_parity_ok"}, parity_ok, 0);
  endtask

  tvec_t tbl[4];
  vec6_t basic_q, basic_r, rq;

  initial begin
    basic_q = pk(5, -3, 7, 2, -9, 4);
`ifdef CNU_OFFSET_EN
    basic_r = pk(1, -1, 1, 2, -1, 1);
    tbl[3] = '{q: pk(1, 1, 5, 5, 5, 5), r: pk(0, 0, 0, 0, 0, 0), par: 1'b1};
`else
    basic_r = pk(2, -2, 2, 3, -2, 2);
    tbl[3] = '{q: pk(1, 1, 5, 5, 5, 5), r: pk(1, 1, 1, 1, 1, 1), par: 1'b1};
`endif
    tbl[0] = '{q: basic_q, r: basic_r, par: 1'b1};
`ifdef CNU_OFFSET_EN
    tbl[1] = '{q: pk(-128, -128, -128, -128, -128, -128),
               r: pk(-126, -126, -126, -126, -126, -126), par: 1'b1};
    tbl[2] = '{q: pk(4, -4, 10, 10, 10, 10), r: pk(-3, 3, -3, -3, -3, -3), par: 1'b0};
`else
    tbl[1] = '{q: pk(-128, -128, -128, -128, -128, -128),
               r: pk(-127, -127, -127, -127, -127, -127), par: 1'b1};
    tbl[2] = '{q: pk(4, -4, 10, 10, 10, 10), r: pk(-4, 4, -4, -4, -4, -4), par: 1'b0};
`endif

    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      feed(tbl[i].q, 0);
      drain(tbl[i].r, tbl[i].par, -1, 0, 1'b0);
    end

    // Input gaps plus a 3-cycle stall on edge 2.
    feed(basic_q, 1);
    drain(basic_r, 1'b1, 2, 3, 1'b0);

    // Reset after three accepts; the aborted check must leave no residue.
    for (int e = 0; e < 3; e++) begin
      in_valid = 1'b1;
      q_in = (e == 0) ? 8'd1 : 8'h80;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_collect");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    feed(basic_q, 0);
    drain(basic_r, 1'b1, -1, 0, 1'b0);

    // Reset in the middle of EMIT.
    feed(tbl[2].q, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_emit");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    feed(basic_q, 0);
    drain(basic_r, 1'b1, -1, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int e = 0; e < NDC; e++) begin
        case ($urandom_range(5, 0))
          0: rq[e] = 8'h80;
          1: rq[e] = 8'h00;
          2: rq[e] = 8'($urandom_range(6, 0) - 3);
          default: rq[e] = 8'($urandom);
        endcase
      end
      feed(rq, 2);
      drain(model_r(rq), model_par(rq), -1, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
